// File: rtl/dma_psdpram_rd_seg.sv
// Segmented simple-dual-port DMA RAM terminating one read-demux port.
// Each segment owns a byte-writable RAM and an elastic read pipeline of depth PIPELINE.
module dma_psdpram_rd_seg #(
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 64,
  parameter int SEG_ADDR_WIDTH = 8,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
  parameter int PIPELINE       = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]    wr_cmd_be,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0]  wr_cmd_addr,
  input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]  wr_cmd_data,
  input  logic [SEG_COUNT-1:0]                 wr_cmd_valid,
  output logic [SEG_COUNT-1:0]                 wr_cmd_ready,
  output logic [SEG_COUNT-1:0]                 wr_done,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0]  rd_cmd_addr,
  input  logic [SEG_COUNT-1:0]                 rd_cmd_valid,
  output logic [SEG_COUNT-1:0]                 rd_cmd_ready,
  output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]  rd_resp_data,
  output logic [SEG_COUNT-1:0]                 rd_resp_valid,
  input  logic [SEG_COUNT-1:0]                 rd_resp_ready
);

  localparam int DEPTH = 2 ** SEG_ADDR_WIDTH;

  for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
    logic [SEG_DATA_WIDTH-1:0]                mem [DEPTH];
    logic [SEG_ADDR_WIDTH-1:0]                wr_addr;
    logic [SEG_ADDR_WIDTH-1:0]                rd_addr;
    logic [SEG_DATA_WIDTH-1:0]                wr_data;
    logic [SEG_BE_WIDTH-1:0]                  wr_be;
    logic                                     wr_fire;
    logic                                     rd_fire;
    logic                                     wr_done_q;
    logic [PIPELINE-1:0]                      pipe_vld_q;
    logic [PIPELINE-1:0]                      pipe_vld_d;
    logic [PIPELINE-1:0]                      stage_rdy;
    logic [PIPELINE-1:0][SEG_DATA_WIDTH-1:0]  pipe_data_q;

    assign wr_addr = wr_cmd_addr[n*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH];
    assign rd_addr = rd_cmd_addr[n*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH];
    assign wr_data = wr_cmd_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];
    assign wr_be   = wr_cmd_be[n*SEG_BE_WIDTH +: SEG_BE_WIDTH];

    // Commands presented while rst is low are ignored, even though ready reads 1.
    assign wr_fire = wr_cmd_valid[n] & rst;

    always_ff @(posedge clk) begin
      if (wr_fire) begin
        for (int b = 0; b < SEG_BE_WIDTH; b++) begin
          if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end

    // A stage can take new contents if it or any stage downstream has a hole,
    // or the consumer is taking the head this cycle.
    always_comb begin
      logic acc;
      stage_rdy = '0;
      acc       = rd_resp_ready[n];
      for (int k = PIPELINE - 1; k >= 0; k--) begin
        acc          = acc | ~pipe_vld_q[k];
        stage_rdy[k] = acc;
      end
    end

    assign rd_fire = rd_cmd_valid[n] & stage_rdy[0] & rst;

    always_comb begin
      pipe_vld_d = pipe_vld_q;
      if (stage_rdy[0]) pipe_vld_d[0] = rd_fire;
      for (int k = 1; k < PIPELINE; k++) begin
        if (stage_rdy[k]) pipe_vld_d[k] = pipe_vld_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        pipe_vld_q <= '0;
        wr_done_q  <= 1'b0;
      end else begin
        pipe_vld_q <= pipe_vld_d;
        wr_done_q  <= wr_cmd_valid[n];
      end
    end

    // Stage 0 captures the RAM word before any same-edge write lands (read-first).
    always_ff @(posedge clk) begin
      if (stage_rdy[0]) pipe_data_q[0] <= mem[rd_addr];
      for (int k = 1; k < PIPELINE; k++) begin
        if (stage_rdy[k]) pipe_data_q[k] <= pipe_data_q[k-1];
      end
    end

    assign wr_cmd_ready[n]  = 1'b1;
    assign wr_done[n]       = wr_done_q;
    assign rd_cmd_ready[n]  = stage_rdy[0] | ~rst;
    assign rd_resp_valid[n] = pipe_vld_q[PIPELINE-1];
    assign rd_resp_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] = pipe_data_q[PIPELINE-1];
  end

endmodule

// File: tb/tb_dma_psdpram_rd_seg.sv
// Bench for dma_psdpram_rd_seg: directed scenarios plus a randomized run against
// a RAM/queue reference model of the segmented read/write behaviour.
module tb_dma_psdpram_rd_seg;
  localparam int SC = 2;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int BW = DW / 8;
  localparam int P  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [SC*BW-1:0]  wr_cmd_be;
  logic [SC*AW-1:0]  wr_cmd_addr;
  logic [SC*DW-1:0]  wr_cmd_data;
  logic [SC-1:0]     wr_cmd_valid;
  logic [SC-1:0]     wr_cmd_ready;
  logic [SC-1:0]     wr_done;
  logic [SC*AW-1:0]  rd_cmd_addr;
  logic [SC-1:0]     rd_cmd_valid;
  logic [SC-1:0]     rd_cmd_ready;
  logic [SC*DW-1:0]  rd_resp_data;
  logic [SC-1:0]     rd_resp_valid;
  logic [SC-1:0]     rd_resp_ready;

  always #5 clk = ~clk;

  dma_psdpram_rd_seg #(
    .SEG_COUNT(SC), .SEG_DATA_WIDTH(DW), .SEG_ADDR_WIDTH(AW),
    .SEG_BE_WIDTH(BW), .PIPELINE(P)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_cmd_be(wr_cmd_be), .wr_cmd_addr(wr_cmd_addr), .wr_cmd_data(wr_cmd_data),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_done(wr_done),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_resp_data(rd_resp_data), .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: RAM image per segment plus an in-order queue of expected
  // responses (data and the cycle the read was accepted).
  logic [DW-1:0] mdl  [SC][2**AW];
  logic [DW-1:0] expd [SC][$];
  int            expc [SC][$];
  logic [SC-1:0] done_pend = '0;
  bit            mon_en    = 1'b0;
  bit            lat_chk   = 1'b0;
  logic          exp_rdy;
  logic [AW-1:0] m_ra, m_wa;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_pd;
  int            m_pc;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int n = 0; n < SC; n++) begin
        exp_rdy = !rst || (expd[n].size() < P) || rd_resp_ready[n];
        chk("rd_cmd_ready", 64'(rd_cmd_ready[n]), 64'(exp_rdy));
        chk("wr_cmd_ready", 64'(wr_cmd_ready[n]), 64'd1);
        chk("wr_done", 64'(wr_done[n]), 64'(done_pend[n]));
        done_pend[n] = wr_cmd_valid[n] & rst;
        if (expd[n].size() == 0) begin
          chk("resp_idle", 64'(rd_resp_valid[n]), 64'd0);
        end else if (rd_resp_valid[n]) begin
          chk("resp_data", rd_resp_data[n*DW +: DW], expd[n][0]);
          if (rd_resp_ready[n]) begin
            m_pd = expd[n].pop_front();
            m_pc = expc[n].pop_front();
            if (lat_chk) chk("latency", 64'(cyc), 64'(m_pc + P));
          end
        end
        m_ra = rd_cmd_addr[n*AW +: AW];
        if (rd_cmd_valid[n] && exp_rdy && rst) begin
          expd[n].push_back(mdl[n][m_ra]);
          expc[n].push_back(cyc);
        end
        m_wa = wr_cmd_addr[n*AW +: AW];
        m_be = wr_cmd_be[n*BW +: BW];
        m_wd = wr_cmd_data[n*DW +: DW];
        if (wr_cmd_valid[n] && rst) begin
          for (int b = 0; b < BW; b++) begin
            if (m_be[b]) mdl[n][m_wa][b*8 +: 8] = m_wd[b*8 +: 8];
          end
        end
        if (!rst) begin
          expd[n].delete();
          expc[n].delete();
        end
      end
    end
  end

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int n, input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    wr_cmd_addr[n*AW +: AW] = AW'(a);
    wr_cmd_data[n*DW +: DW] = d;
    wr_cmd_be[n*BW +: BW]   = be;
    wr_cmd_valid[n]         = 1'b1;
  endtask

  task automatic rd(input int n, input int a);
    rd_cmd_addr[n*AW +: AW] = AW'(a);
    rd_cmd_valid[n]         = 1'b1;
  endtask

  logic [DW-1:0] got [$];

  initial begin
    rst = 1'b0;
    wr_cmd_be = '0; wr_cmd_addr = '0; wr_cmd_data = '0; wr_cmd_valid = '0;
    rd_cmd_addr = '0; rd_cmd_valid = '0; rd_resp_ready = '1;
    step();
    chk("rst_resp_valid", 64'(rd_resp_valid), 64'd0);
    chk("rst_wr_done", 64'(wr_done), 64'd0);
    chk("rst_rd_ready", 64'(rd_cmd_ready), 64'h3);
    chk("rst_wr_ready", 64'(wr_cmd_ready), 64'h3);
    mon_en = 1'b1;
    step();
    rst = 1'b1;

    for (int a = 0; a < 2**AW; a++) begin
      wr(0, a, (a < 16) ? pat(a) : {$urandom, $urandom}, 8'hFF);
      wr(1, a, {$urandom, $urandom}, 8'hFF);
      step();
    end
    wr_cmd_valid = '0;
    step();

    // Independent segments, done pulses, fixed latency
    lat_chk = 1'b1;
    wr(0, 'h10, 64'h1122334455667788, 8'hFF);
    step();
    chk("t1_done_seg0", 64'(wr_done), 64'h1);
    wr_cmd_valid = '0;
    wr(1, 'h10, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    step();
    chk("t1_done_seg1", 64'(wr_done), 64'h2);
    wr_cmd_valid = '0;
    step();
    chk("t1_done_idle", 64'(wr_done), 64'h0);
    rd(0, 'h10);
    rd(1, 'h10);
    step();
    rd_cmd_valid = '0;
    for (int k = 1; k < P; k++) begin
      chk("t1_early", 64'(rd_resp_valid), 64'h0);
      step();
    end
    chk("t1_valid", 64'(rd_resp_valid), 64'h3);
    chk("t1_data0", rd_resp_data[0 +: DW], 64'h1122334455667788);
    chk("t1_data1", rd_resp_data[DW +: DW], 64'hAAAAAAAAAAAAAAAA);
    step();
    chk("t1_after", 64'(rd_resp_valid), 64'h0);

    // Partial byte-enable write
    wr(0, 'h20, '1, 8'hFF);
    step();
    wr(0, 'h20, '0, 8'h0F);
    step();
    wr_cmd_valid = '0;
    rd(0, 'h20);
    step();
    rd_cmd_valid = '0;
    repeat (P - 1) step();
    chk("t2_valid", 64'(rd_resp_valid[0]), 64'd1);
    chk("t2_partial", rd_resp_data[0 +: DW], 64'hFFFFFFFF00000000);
    step();

    // Streaming reads at full rate
    for (int k = 0; k < 8 + P; k++) begin
      if (k < 8) begin
        rd(0, k);
        chk("t3_cmd_ready", 64'(rd_cmd_ready[0]), 64'd1);
      end else begin
        rd_cmd_valid = '0;
      end
      step();
      if (k + 1 < P) chk("t3_early", 64'(rd_resp_valid[0]), 64'd0);
      else if (k + 1 - P < 8) begin
        chk("t3_valid", 64'(rd_resp_valid[0]), 64'd1);
        chk("t3_data", rd_resp_data[0 +: DW], pat(k + 1 - P));
      end
    end
    rd_cmd_valid = '0;
    step();

    // Backpressure: fill, hold, drain in order
    lat_chk = 1'b0;
    rd_resp_ready[0] = 1'b0;
    for (int k = 1; k <= P; k++) begin
      rd(0, k);
      chk("t4_accept", 64'(rd_cmd_ready[0]), 64'd1);
      step();
    end
    rd(0, P + 1);
    chk("t4_full", 64'(rd_cmd_ready[0]), 64'd0);
    repeat (3) begin
      step();
      chk("t4_hold_valid", 64'(rd_resp_valid[0]), 64'd1);
      chk("t4_hold_data", rd_resp_data[0 +: DW], pat(1));
      chk("t4_still_full", 64'(rd_cmd_ready[0]), 64'd0);
    end
    rd_resp_ready[0] = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (rd_resp_valid[0]) got.push_back(rd_resp_data[0 +: DW]);
      step();
      if (i == 0) rd_cmd_valid = '0;
    end
    chk("t4_count", 64'(got.size()), 64'(P + 1));
    for (int j = 0; j < P + 1; j++) begin
      if (j < got.size()) chk("t4_order", got[j], pat(j + 1));
    end
    lat_chk = 1'b1;

    // Same-cycle read/write collision is read-first
    wr(0, 'h30, 64'h5, 8'hFF);
    step();
    wr(0, 'h30, 64'h9, 8'hFF);
    rd(0, 'h30);
    step();
    wr_cmd_valid = '0;
    rd(0, 'h30);
    step();
    rd_cmd_valid = '0;
    for (int k = 2; k < P; k++) step();
    chk("t5_old", rd_resp_data[0 +: DW], 64'h5);
    step();
    chk("t5_new", rd_resp_data[0 +: DW], 64'h9);
    step();

    // Reset with reads in flight; commands during reset are ignored
    lat_chk = 1'b0;
    wr(0, 'h40, 64'hDEADBEEFCAFEF00D, 8'hFF);
    step();
    wr_cmd_valid = '0;
    rd_resp_ready[0] = 1'b0;
    rd(0, 1);
    step();
    rd(0, 2);
    step();
    rd_cmd_valid = '0;
    rst = 1'b0;
    wr(0, 'h40, 64'h0, 8'hFF);
    rd(0, 'h40);
    step();
    chk("t6_valid_cleared", 64'(rd_resp_valid), 64'h0);
    chk("t6_rdy_in_rst", 64'(rd_cmd_ready), 64'h3);
    chk("t6_done_in_rst", 64'(wr_done), 64'h0);
    rst = 1'b1;
    wr_cmd_valid = '0;
    rd_cmd_valid = '0;
    rd_resp_ready[0] = 1'b1;
    repeat (6) begin
      step();
      chk("t6_no_late", 64'(rd_resp_valid[0]), 64'd0);
    end
    rd(0, 'h40);
    step();
    rd_cmd_valid = '0;
    repeat (P - 1) step();
    chk("t6_valid", 64'(rd_resp_valid[0]), 64'd1);
    chk("t6_ram_kept", rd_resp_data[0 +: DW], 64'hDEADBEEFCAFEF00D);
    step();

    // Randomized traffic with backpressure, collisions and occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < SC; n++) begin
        wr_cmd_valid[n]          = 1'($urandom_range(0, 1));
        wr_cmd_addr[n*AW +: AW]  = AW'($urandom_range(0, 15));
        wr_cmd_be[n*BW +: BW]    = BW'($urandom);
        wr_cmd_data[n*DW +: DW]  = {$urandom, $urandom};
        rd_cmd_valid[n]          = ($urandom_range(0, 4) < 3);
        rd_cmd_addr[n*AW +: AW]  = AW'($urandom_range(0, 15));
        rd_resp_ready[n]         = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 499) != 0);
      step();
    end
    rst = 1'b1;
    wr_cmd_valid = '0;
    rd_cmd_valid = '0;
    rd_resp_ready = '1;
    repeat (P + 4) step();
    for (int n = 0; n < SC; n++) chk("drain_empty", 64'(expd[n].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_psdpram_rd_seg.md
Name: dma_psdpram_rd_seg

Overview:
- Segmented simple-dual-port DMA RAM that sits directly downstream of the read demux and terminates one demux output port.
- Read side accepts per-segment read commands (addr, valid/ready) and returns per-segment read data through a configurable output pipeline with full ready/valid backpressure.
- Write side provides per-segment byte-enabled writes with a done pulse, so the RAM can be loaded and checked in-system.
- Segments are fully independent; there is no cross-segment ordering.

Parameters:
- SEG_COUNT, 2, number of RAM segments
- SEG_DATA_WIDTH, 64, data bits per segment
- SEG_ADDR_WIDTH, 8, word address bits per segment; depth is 2^SEG_ADDR_WIDTH words per segment
- SEG_BE_WIDTH, SEG_DATA_WIDTH/8, byte enables per segment
- PIPELINE, 2, read pipeline depth (1..4) = cycles from command acceptance to response valid

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- wr_cmd_be  input  SEG_COUNT*SEG_BE_WIDTH  per-segment write byte enables
- wr_cmd_addr  input  SEG_COUNT*SEG_ADDR_WIDTH  per-segment write word address
- wr_cmd_data  input  SEG_COUNT*SEG_DATA_WIDTH  per-segment write data
- wr_cmd_valid  input  SEG_COUNT  per-segment write command valid
- wr_cmd_ready  output  SEG_COUNT  per-segment write command ready
- wr_done  output  SEG_COUNT  per-segment one-cycle write-complete pulse
- rd_cmd_addr  input  SEG_COUNT*SEG_ADDR_WIDTH  per-segment read word address
- rd_cmd_valid  input  SEG_COUNT  per-segment read command valid
- rd_cmd_ready  output  SEG_COUNT  per-segment read command ready
- rd_resp_data  output  SEG_COUNT*SEG_DATA_WIDTH  per-segment read data
- rd_resp_valid  output  SEG_COUNT  per-segment read response valid
- rd_resp_ready  input  SEG_COUNT  per-segment read response ready

Behaviour:
- Reset: active when rst==0 at a clk edge.
  - Clears all pipeline valid bits, so rd_resp_valid=0 and wr_done=0.
  - During reset: wr_cmd_ready=1 and rd_cmd_ready=1, but no command issued while rst==0 takes effect.
  - RAM contents are not cleared. Pipeline data registers are don't-care.
  - Reset mid-operation discards every in-flight read; there is no late response after reset release.
- Write, per segment n:
  - wr_cmd_ready[n] is constant 1.
  - On wr_cmd_valid[n], each byte b with be[b]=1 is written at addr; bytes with be[b]=0 are unchanged.
  - wr_done[n]=1 exactly one cycle after acceptance, for one cycle per accepted write. Back-to-back writes give a continuous done.
  - be=0 with valid=1 is still accepted and still pulses done.
- Read pipeline, per segment n:
  - Stages s0..s(PIPELINE-1), each with a valid bit and a data register.
  - Accepted command (rd_cmd_valid & rd_cmd_ready) loads s0 with RAM[addr] (synchronous read) and sets s0 valid.
  - Last stage drives rd_resp_data/rd_resp_valid.
  - Stage k advances when stage k+1 is empty or advancing; the last stage advances when rd_resp_ready[n]=1.
  - rd_cmd_ready[n] = ~s0.valid | s0 advancing, which gives full throughput of one read per cycle with no bubbles under continuous ready.
- Latency: response valid exactly PIPELINE cycles after acceptance when there is no backpressure.
- Backpressure:
  - While rd_resp_valid=1 and rd_resp_ready=0, rd_resp_data holds stable.
  - Pipeline fills; at most PIPELINE reads are outstanding, then rd_cmd_ready drops to 0 in the same cycle the pipeline is full and not advancing.
  - Releasing ready drains one per cycle in order; no loss or duplication.
- Ordering: responses per segment are in command order.
- Collision: read and write to the same segment and address in the same cycle return old data (read-first); the new data is visible to reads accepted on the following cycle or later.
- Addresses wrap naturally within SEG_ADDR_WIDTH; no range checking.

Test Plan:
- Write seg0 addr 0x10 data 0x1122334455667788 be 0xFF; write seg1 addr 0x10 data 0xAAAA... -> wr_done=2'b01 then 2'b10 one cycle after each; read both addr 0x10 -> data returned exactly 2 cycles later, segments independent.
- Partial write: write addr 0x20 data all-ones be 0xFF, then data 0 be 0x0F -> read returns 0xFFFFFFFF00000000.
- Stream reads addr 0..7 on seg0 with rd_resp_ready=1 -> rd_cmd_ready stays 1; 8 consecutive responses in order; first response 2 cycles after first command.
- rd_resp_ready=0 while issuing reads addr 1,2,3 -> 2 accepted, rd_cmd_ready=0 on the third, data held stable; ready=1 -> drain in order 1,2,3 with no duplicates.
- Same-cycle read and write addr 0x30 (old 0x5, new 0x9) -> response 0x5; next-cycle read -> 0x9.
- Assert rst=0 with 2 reads in flight -> rd_resp_valid=0 next cycle and no responses after release; RAM data written before reset still reads back correctly.
